// File: rtl/multicycle_control_32.sv
// rtl/multicycle_control_32.sv - multi-cycle MIPS sequencer FSM with memory ready handshake
module multicycle_control_32 #(
    parameter int STATE_W = 4,
    parameter int OP_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic [OP_W-1:0]    funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         mem_toreg,
    output logic [1:0]         reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               err_illegal_opcode,
    output logic [STATE_W-1:0] state
);

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BEQ       = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_ERROR     = 4'd14,
        S_UNUSED    = 4'd15
    } state_t;

    state_t state_q, state_d;

    // State register; reset always lands in FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state strobes; reset forces everything quiet
    always_comb begin
        state_d            = S_FETCH;
        pc_write           = 1'b0;
        pc_write_cond      = 1'b0;
        i_or_d             = 1'b0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        ir_write           = 1'b0;
        mem_toreg          = 2'b00;
        reg_dst            = 2'b00;
        reg_write          = 1'b0;
        alu_src_a          = 1'b0;
        alu_src_b          = 2'b00;
        alu_op             = 2'b00;
        pc_source          = 2'b00;
        instr_done         = 1'b0;
        err_illegal_opcode = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    state_d   = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_ADDI:      state_d = S_ADDI_EXEC;
                        OP_J:         state_d = S_JUMP;
                        OP_JAL:       state_d = S_JAL;
                        default:      state_d = S_ERROR;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_toreg  = 2'b01;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                    state_d    = mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_R_WB;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b01;
                    instr_done = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_toreg  = 2'b10;
                    instr_done = 1'b1;
                end
                S_JR: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b11;
                    instr_done = 1'b1;
                end
                S_ERROR: begin
                    // Parked until reset so the flag stays up
                    err_illegal_opcode = 1'b1;
                    state_d            = S_ERROR;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state = rst ? '0 : state_q;

endmodule
